// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle signed divider: default width and FSM state encodings.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_SIGN = 2'd2
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// The remainder shifts left and takes the quotient's MSB. The quotient shifts left.
// If the shifted remainder is at least the divisor, the divisor is subtracted and quotient bit 0 is set.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Shift, trial-compare on WIDTH+1 bits, and conditionally subtract.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        // The difference is only used when shifted >= divisor.
        // In that case it is below the divisor, so WIDTH bits are enough.
        diff    = shifted[WIDTH-1:0] - dvsr_i;
        rem_o   = shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, dvsr_i}) begin
            rem_o    = diff;
            quo_o[0] = 1'b1;
        end
    end

endmodule : div_step

// File: rtl/div_unit.sv
// Multicycle signed divider (MIPS DIV semantics): quotient on lo, remainder on hi.
// Operands are converted to magnitudes, divided over WIDTH restoring steps, then sign-corrected.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             quo_sign_q, quo_sign_d;
    logic             rem_sign_q, rem_sign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_step),
        .quo_o  (quo_step)
    );

    // Next-state, datapath updates and output pulses for the IDLE/CALC/SIGN sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case.
        // A path that leaves one unassigned would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        quo_sign_d = quo_sign_q;
        rem_sign_d = rem_sign_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // hi/lo are left untouched so the previous result stays readable.
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        dvsr_d     = divisor[WIDTH-1]  ? -divisor  : divisor;
                        quo_d      = dividend[WIDTH-1] ? -dividend : dividend;
                        rem_d      = '0;
                        cnt_d      = '0;
                        quo_sign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rem_sign_d = dividend[WIDTH-1];
                        state_d    = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_SIGN;
                end
            end
            DIV_SIGN: begin
                // Modular negation makes MIN / -1 come out as MIN with a zero remainder.
                lo_d    = quo_sign_q ? -quo_q : quo_q;
                hi_d    = rem_sign_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            quo_sign_q <= 1'b0;
            rem_sign_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its pre-edge value,
            // independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            quo_sign_q <= quo_sign_d;
            rem_sign_q <= rem_sign_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign busy     = (state_q == DIV_CALC) || (state_q == DIV_SIGN);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Directed and random signed divisions are compared against a 64-bit arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;

    // Expected architectural hi/lo; these persist across operations like the real registers.
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero),
        .busy     (busy),
        .done     (done)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: MIPS DIV via 64-bit signed arithmetic (truncating quotient, remainder follows dividend).
    task automatic model(input logic [31:0] a, input logic [31:0] b);
        longint a64;
        longint b64;
        longint q64;
        longint r64;
        if (b != 32'd0) begin
            a64    = longint'($signed(a));
            b64    = longint'($signed(b));
            q64    = a64 / b64;
            r64    = a64 % b64;
            exp_lo = q64[31:0];
            exp_hi = r64[31:0];
        end
    endtask

    // Issue one divide from the current cycle, wait for done (bounded), and check the result.
    // If inject is set, a second start with 9/3 is pulsed at edge 5, while the unit is busy.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit inject, input string tag);
        int n;
        int busy_bad;
        int exp_lat;
        model(a, b);
        exp_lat  = (b == 32'd0) ? 0 : 33;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        n        = 0;
        busy_bad = 0;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (inject && n == 4) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
            n++;
            if (inject && n == 5) start = 1'b0;
        end
        check({tag, " latency"},  32'(n), 32'(exp_lat));
        check({tag, " busy_run"}, 32'(busy_bad), 32'd0);
        check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, (b == 32'd0)});
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " hi"}, hi, exp_hi);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen_done;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst hi",       hi,                 32'd0);
        check("rst lo",       lo,                 32'd0);
        check("rst busy",     {31'd0, busy},      32'd0);
        check("rst done",     {31'd0, done},      32'd0);
        check("rst div_zero", {31'd0, div_zero},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle done", {31'd0, done}, 32'd0);

        // Directed cases; back-to-back calls start in the cycle where done is high.
        run_div(32'd7,        32'd2,        1'b0, "7/2");
        run_div(32'd5,        32'd0,        1'b0, "5/0");
        run_div(32'hFFFFFFF9, 32'd2,        1'b0, "-7/2");
        run_div(32'd7,        32'hFFFFFFFE, 1'b0, "7/-2");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, "min/-1");
        run_div(32'd100,      32'd7,        1'b1, "100/7 inject");

        // Without a new start, done must drop after a single cycle.
        @(posedge clk);
        #1;
        check("done pulse", {31'd0, done},     32'd0);
        check("dz pulse",   {31'd0, div_zero}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi",   hi,            32'd0);
        check("midrst lo",   lo,            32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("midrst no done", 32'(seen_done), 32'd0);
        run_div(32'd9, 32'd3, 1'b0, "9/3 after rst");

        // Random operands mixing extremes, small values and zero divisors.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = -($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_div_unit
